// File: rtl/const_div_pkg.sv
// Shared types and elaboration helpers for the constant-divisor digit-serial divider.
// Holds the FSM state encoding, the remainder-width rule and the {q, r} step-table builder.
// Everything here is evaluated at elaboration or folded into constant-divisor logic.
package const_div_pkg;

  // Controller states: waiting for a dividend, running the recurrence, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest width that can hold every remainder 0..d-1 (equals $clog2(d) for d >= 2).
  function automatic int rem_width(input int d);
    int w;
    w = 1;
    while ((1 << w) < d) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Entry t of the {q, r} step table for divisor d: q = t / d in the bits above rw,
  // r = t % d in the low rw bits. Evaluating it for every t in 0 .. 2^(rw+k)-1 gives
  // the full table; with d fixed, synthesis reduces it to constant-division logic.
  function automatic logic [31:0] step_entry(input int unsigned t,
                                             input int unsigned d,
                                             input int unsigned rw);
    int unsigned qq;
    int unsigned rr;
    qq = t / d;
    rr = t % d;
    return (qq << rw) | rr;
  endfunction

endpackage

// File: rtl/const_div_step.sv
// One digit of the remainder recurrence: {rem, digit} divided by the constant D.
// Purely combinational, zero latency.
// No handshake; the caller guarantees rem < D, which keeps q within K bits.
module const_div_step
  import const_div_pkg::*;
#(
  parameter int D  = 23,
  parameter int K  = 4,
  parameter int RW = rem_width(D)
) (
  input  logic [RW-1:0] rem,
  input  logic [K-1:0]  digit,
  output logic [K-1:0]  q,
  output logic [RW-1:0] r
);

  localparam int TW = RW + K;

  logic [TW-1:0] t;
  logic [31:0]   ent;

  // Look up the partial dividend in the constant step table and split it into q and r.
  always_comb begin
    t   = {rem, digit};
    ent = step_entry(32'(t), D, RW);
    q   = K'(ent >> RW);
    r   = RW'(ent);
  end

endmodule

// File: rtl/const_div_seq.sv
// Digit-serial unsigned divide of an N-bit dividend by the constant D, K quotient bits per clock.
// Latency: accept edge plus N/K recurrence clocks; out_valid rises after the last step edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no overlap.
module const_div_seq
  import const_div_pkg::*;
#(
  parameter int N  = 64,
  parameter int D  = 23,
  parameter int K  = 4,
  parameter int RW = rem_width(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_dividend,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_quot,
  output logic [RW-1:0] out_rem,
  output logic          busy
);

  // Number of recurrence steps and a counter wide enough to reach it.
  localparam int STEPS = N / K;
  localparam int CW    = rem_width(STEPS + 1);

  // Reject configurations the recurrence cannot support.
  if (N % K != 0) begin : g_bad_nk
    $error("const_div_seq: N (%0d) must be a multiple of K (%0d)", N, K);
  end
  if (D < 2) begin : g_bad_dlo
    $error("const_div_seq: D (%0d) must be at least 2", D);
  end
  if (D >= 65536) begin : g_bad_dhi
    $error("const_div_seq: D (%0d) must be below 2^16", D);
  end
  if (K < 1 || K > 8) begin : g_bad_k
    $error("const_div_seq: K (%0d) must be in 1..8", K);
  end

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          step_en;
  logic          last_step;

  // The shift register starts as the dividend; quotient digits enter at the bottom
  // as dividend digits leave at the top, so after STEPS shifts it holds the quotient.
  logic [N-1:0]  shreg;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;

  logic [K-1:0]  digit;
  logic [K-1:0]  q_dig;
  logic [RW-1:0] r_nxt;

  assign digit = shreg[N-1 -: K];

  const_div_step #(
    .D  (D),
    .K  (K),
    .RW (RW)
  ) u_step (
    .rem   (rem),
    .digit (digit),
    .q     (q_dig),
    .r     (r_nxt)
  );

  // State register; reset aborts any division in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; outputs depend on the state register only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step_en   = 1'b0;
    last_step = (cnt == CW'(STEPS - 1));
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, then one quotient digit and one remainder update per BUSY clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= in_dividend;
      rem   <= '0;
      cnt   <= '0;
    end else if (step_en) begin
      // Shift form (rather than a slice) stays legal when N == K.
      shreg <= (shreg << K) | N'(q_dig);
      rem   <= r_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  // In DONE the shift register is the quotient and rem the final remainder; both
  // are frozen there because nothing updates them outside accept/step.
  assign out_quot = shreg;
  assign out_rem  = rem;

endmodule

// File: tb/tb_const_div_seq.sv
// Scoreboard bench for const_div_seq: default config plus three parameter sweeps,
// and exhaustive sweeps of const_div_step in each sweep configuration.
module tb_const_div_seq;
  import const_div_pkg::*;

  typedef struct packed {
    logic [63:0] quot;
    logic [15:0] rem;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_sw;

  int checks = 0;
  int errors = 0;

  exp_t q_main[$];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // Default configuration: N=64, D=23, K=4.
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_dividend, out_quot;
  logic [4:0]  out_rem;

  const_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .busy(busy)
  );

  logic sw_ordy;

  // Sweep A: N=32, D=7, K=1.
  logic        a_iv, a_ir, a_ov, a_busy;
  logic [31:0] a_div, a_quot;
  logic [2:0]  a_rem;
  const_div_seq #(.N(32), .D(7), .K(1)) dut_a (
    .clk(clk), .rst(rst_sw), .in_valid(a_iv), .in_ready(a_ir), .in_dividend(a_div),
    .out_valid(a_ov), .out_ready(sw_ordy), .out_quot(a_quot), .out_rem(a_rem), .busy(a_busy)
  );

  // Sweep B: N=48, D=23, K=8.
  logic        b_iv, b_ir, b_ov, b_busy;
  logic [47:0] b_div, b_quot;
  logic [4:0]  b_rem;
  const_div_seq #(.N(48), .D(23), .K(8)) dut_b (
    .clk(clk), .rst(rst_sw), .in_valid(b_iv), .in_ready(b_ir), .in_dividend(b_div),
    .out_valid(b_ov), .out_ready(sw_ordy), .out_quot(b_quot), .out_rem(b_rem), .busy(b_busy)
  );

  // Sweep C: N=64, D=1000, K=2.
  logic        c_iv, c_ir, c_ov, c_busy;
  logic [63:0] c_div, c_quot;
  logic [9:0]  c_rem;
  const_div_seq #(.N(64), .D(1000), .K(2)) dut_c (
    .clk(clk), .rst(rst_sw), .in_valid(c_iv), .in_ready(c_ir), .in_dividend(c_div),
    .out_valid(c_ov), .out_ready(sw_ordy), .out_quot(c_quot), .out_rem(c_rem), .busy(c_busy)
  );

  // Standalone step tables for the three sweep configurations.
  logic [2:0] sa_rem, sa_r;  logic [0:0] sa_dig, sa_q;
  logic [4:0] sb_rem, sb_r;  logic [7:0] sb_dig, sb_q;
  logic [9:0] sc_rem, sc_r;  logic [1:0] sc_dig, sc_q;
  const_div_step #(.D(7),    .K(1)) st_a (.rem(sa_rem), .digit(sa_dig), .q(sa_q), .r(sa_r));
  const_div_step #(.D(23),   .K(8)) st_b (.rem(sb_rem), .digit(sb_dig), .q(sb_q), .r(sb_r));
  const_div_step #(.D(1000), .K(2)) st_c (.rem(sc_rem), .digit(sc_dig), .q(sc_q), .r(sc_r));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic sb_cmp(input string name, input logic [63:0] gq, input logic [15:0] gr,
                        input exp_t e);
    checks++;
    if (gq !== e.quot || gr !== e.rem) begin
      errors++;
      $display("FAIL %s: got q=%0d r=%0d, expected q=%0d r=%0d", name, gq, gr, e.quot, e.rem);
    end
  endtask

  task automatic sb_unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: result presented with empty scoreboard", name);
  endtask

  // Monitor: pops the scoreboard whenever a DUT completes an output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q_main.size() == 0) sb_unexpected("main_out");
      else begin e = q_main.pop_front(); sb_cmp("main_out", out_quot, 16'(out_rem), e); end
    end
    if (!rst_sw && a_ov && sw_ordy) begin
      if (q_a.size() == 0) sb_unexpected("sweep_a_out");
      else begin e = q_a.pop_front(); sb_cmp("sweep_a_out", 64'(a_quot), 16'(a_rem), e); end
    end
    if (!rst_sw && b_ov && sw_ordy) begin
      if (q_b.size() == 0) sb_unexpected("sweep_b_out");
      else begin e = q_b.pop_front(); sb_cmp("sweep_b_out", 64'(b_quot), 16'(b_rem), e); end
    end
    if (!rst_sw && c_ov && sw_ordy) begin
      if (q_c.size() == 0) sb_unexpected("sweep_c_out");
      else begin e = q_c.pop_front(); sb_cmp("sweep_c_out", c_quot, 16'(c_rem), e); end
    end
  end

  function automatic logic ready_of(input int c);
    case (c)
      0: return a_ir;
      1: return b_ir;
      2: return c_ir;
      default: return in_ready;
    endcase
  endfunction

  // Offer one dividend to DUT c (3 = default DUT); returns one cycle after the accept edge.
  task automatic send(input int c, input logic [63:0] dv, input exp_t e, input bit push);
    int n;
    n = 0;
    while (!ready_of(c) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!ready_of(c)) begin
      checks++; errors++;
      $display("FAIL accept_timeout: dut %0d in_ready low for %0d cycles, expected 1", c, n);
    end
    if (push) begin
      case (c)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        2: q_c.push_back(e);
        default: q_main.push_back(e);
      endcase
    end
    case (c)
      0: begin a_div = dv[31:0]; a_iv = 1'b1; end
      1: begin b_div = dv[47:0]; b_iv = 1'b1; end
      2: begin c_div = dv;       c_iv = 1'b1; end
      default: begin in_dividend = dv; in_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_main.size() + q_a.size() + q_b.size() + q_c.size()) != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if ((q_main.size() + q_a.size() + q_b.size() + q_c.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0",
               q_main.size() + q_a.size() + q_b.size() + q_c.size());
    end
  endtask

  // Directed vectors for the default configuration (D = 23), hand-computed.
  logic [63:0] vec_div [6];
  exp_t        vec_exp [6];

  initial begin
    int          lat;
    int          n;
    int          t;
    logic [63:0] dv;
    logic [63:0] dm;
    exp_t        e;

    vec_div[0] = 64'd1000;                 vec_exp[0] = '{quot: 64'd43, rem: 16'd11};
    vec_div[1] = 64'hFFFF_FFFF_FFFF_FFFF;  vec_exp[1] = '{quot: 64'd802032351030850070, rem: 16'd5};
    vec_div[2] = 64'd0;                    vec_exp[2] = '{quot: 64'd0, rem: 16'd0};
    vec_div[3] = 64'd22;                   vec_exp[3] = '{quot: 64'd0, rem: 16'd22};
    vec_div[4] = 64'd23;                   vec_exp[4] = '{quot: 64'd1, rem: 16'd0};
    vec_div[5] = 64'd46;                   vec_exp[5] = '{quot: 64'd2, rem: 16'd0};

    rst = 1'b1; rst_sw = 1'b1;
    in_valid = 1'b0; in_dividend = '0; out_ready = 1'b1;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; a_div = '0; b_div = '0; c_div = '0;
    sw_ordy = 1'b1;
    sa_rem = '0; sa_dig = '0; sb_rem = '0; sb_dig = '0; sc_rem = '0; sc_dig = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_out_quot",  out_quot,       64'd0);
    chk("reset_out_rem",   64'(out_rem),   64'd0);
    rst = 1'b0; rst_sw = 1'b0;

    // Exhaustive step-table sweeps over every (rem < D, digit) pair.
    for (int r0 = 0; r0 < 7; r0++) begin
      for (int d0 = 0; d0 < 2; d0++) begin
        sa_rem = 3'(r0); sa_dig = 1'(d0); #1;
        t = r0 * 2 + d0;
        chk("step_a_q", 64'(sa_q), 64'(t / 7));
        chk("step_a_r", 64'(sa_r), 64'(t % 7));
      end
    end
    for (int r0 = 0; r0 < 23; r0++) begin
      for (int d0 = 0; d0 < 256; d0++) begin
        sb_rem = 5'(r0); sb_dig = 8'(d0); #1;
        t = r0 * 256 + d0;
        chk("step_b_q", 64'(sb_q), 64'(t / 23));
        chk("step_b_r", 64'(sb_r), 64'(t % 23));
      end
    end
    for (int r0 = 0; r0 < 1000; r0++) begin
      for (int d0 = 0; d0 < 4; d0++) begin
        sc_rem = 10'(r0); sc_dig = 2'(d0); #1;
        t = r0 * 4 + d0;
        chk("step_c_q", 64'(sc_q), 64'(t / 1000));
        chk("step_c_r", 64'(sc_r), 64'(t % 1000));
      end
    end

    // Latency: the accept edge is clock 1, so out_valid must first be seen after clock 17.
    @(posedge clk); #1;
    send(3, vec_div[0], vec_exp[0], 1'b1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency_clocks", 64'(lat), 64'd17);
    drain();

    // Directed vectors, including the D-1, D and 2D boundaries.
    for (int i = 1; i < 6; i++) begin
      send(3, vec_div[i], vec_exp[i], 1'b1);
      drain();
    end

    // Backpressure: result must hold for 10 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    send(3, vec_div[1], vec_exp[1], 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_dividend = 64'd5;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_quot",  out_quot,       vec_exp[1].quot);
      chk("bp_out_rem",   64'(out_rem),   64'(vec_exp[1].rem));
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_release", 64'(in_ready), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_no_ghost_valid", 64'(out_valid), 64'd0);
    chk("bp_no_ghost_busy",  64'(busy),      64'd0);
    drain();

    // Reset after seven recurrence steps discards the partial result.
    e = '{quot: 64'd0, rem: 16'd0};
    send(3, 64'd5555, e, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy",      64'(busy),      64'd0);
    chk("abort_out_quot",  out_quot,       64'd0);
    chk("abort_out_rem",   64'(out_rem),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(3, vec_div[0], vec_exp[0], 1'b1);
    drain();

    // Parameter sweeps against a golden divide; all-ones dividend plus random ones.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 7; i++) begin
        dv = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        case (c)
          0: begin dm = {32'd0, dv[31:0]}; e.quot = dm / 64'd7;    e.rem = 16'(dm % 64'd7);    end
          1: begin dm = {16'd0, dv[47:0]}; e.quot = dm / 64'd23;   e.rem = 16'(dm % 64'd23);   end
          default: begin dm = dv;          e.quot = dm / 64'd1000; e.rem = 16'(dm % 64'd1000); end
        endcase
        send(c, dv, e, 1'b1);
      end
      drain();
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
